// File: rtl/kw_schedule_quad_if.sv
// Block-load / KW-quad bus between a block source, the schedule expander
// and the downstream digest quad stage.
interface kw_schedule_quad_if #(
  parameter int WORDBITS   = 32,
  parameter int BLOCKWORDS = 16
);
  logic                           start;
  logic [WORDBITS*BLOCKWORDS-1:0] block_in;
  logic                           ready;
  logic                           kw_valid;
  logic [3:0]                     quad_idx;
  logic                           last;
  logic [WORDBITS-1:0]            KW0_out;
  logic [WORDBITS-1:0]            KW1_out;
  logic [WORDBITS-1:0]            KW2_out;
  logic [WORDBITS-1:0]            KW3_out;

  modport master (
    output start, block_in,
    input  ready, kw_valid, quad_idx, last, KW0_out, KW1_out, KW2_out, KW3_out
  );

  modport slave (
    input  start, block_in,
    output ready, kw_valid, quad_idx, last, KW0_out, KW1_out, KW2_out, KW3_out
  );
endinterface

// File: rtl/kw_schedule_quad.sv
// SHA-256 message-schedule expander: emits K[t]+W[t] four words per clock,
// sixteen quads per 512-bit block, with bubble-free back-to-back blocks.
module kw_schedule_quad #(
  parameter int WORDBITS   = 32,
  parameter int BLOCKWORDS = 16
) (
  input  logic            clk,
  input  logic            reset,
  kw_schedule_quad_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t              state_reg, state_next;
  logic [3:0]          q_reg, q_next;
  logic [WORDBITS-1:0] window_reg  [BLOCKWORDS];
  logic [WORDBITS-1:0] window_next [BLOCKWORDS];
  logic [WORDBITS-1:0] w_lo [2];
  logic [WORDBITS-1:0] w_hi [2];
  logic [WORDBITS-1:0] quad_w [4];
  logic [WORDBITS-1:0] kw_calc [4];
  logic [WORDBITS-1:0] kw_reg [4];
  logic [WORDBITS-1:0] kw_next [4];
  logic                kw_valid_reg, kw_valid_next;
  logic                last_reg, last_next;
  logic [3:0]          quad_idx_reg, quad_idx_next;
  logic                ready;
  logic                accept;

  // Window holds W[t-16..t-1]; the upper pair of the quad chains off the lower pair.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lo
      assign w_lo[gi] = sig1(window_reg[14+gi]) + window_reg[9+gi]
                      + sig0(window_reg[1+gi]) + window_reg[gi];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_hi
      assign w_hi[gi] = sig1(w_lo[gi]) + window_reg[11+gi]
                      + sig0(window_reg[3+gi]) + window_reg[2+gi];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_kw
      if (gi < 2) begin : g_sel_lo
        assign quad_w[gi] = (q_reg < 4'd4) ? window_reg[{q_reg[1:0], 2'(gi)}] : w_lo[gi];
      end else begin : g_sel_hi
        assign quad_w[gi] = (q_reg < 4'd4) ? window_reg[{q_reg[1:0], 2'(gi)}] : w_hi[gi-2];
      end
      assign kw_calc[gi] = K_ROM[{q_reg, 2'(gi)}] + quad_w[gi];
    end
  endgenerate

  assign ready  = (state_reg == IDLE) || (state_reg == RUN && q_reg == 4'd15);
  assign accept = bus.start && ready;

  always_comb begin
    state_next    = state_reg;
    q_next        = q_reg;
    window_next   = window_reg;
    kw_next       = kw_reg;
    kw_valid_next = 1'b0;
    last_next     = 1'b0;
    quad_idx_next = quad_idx_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          for (int i = 0; i < BLOCKWORDS; i++)
            window_next[i] = bus.block_in[WORDBITS*i +: WORDBITS];
          q_next     = 4'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        kw_valid_next = 1'b1;
        last_next     = (q_reg == 4'd15);
        quad_idx_next = q_reg;
        kw_next       = kw_calc;
        if (q_reg >= 4'd4) begin
          for (int i = 0; i < BLOCKWORDS - 4; i++)
            window_next[i] = window_reg[i+4];
          window_next[BLOCKWORDS-4] = w_lo[0];
          window_next[BLOCKWORDS-3] = w_lo[1];
          window_next[BLOCKWORDS-2] = w_hi[0];
          window_next[BLOCKWORDS-1] = w_hi[1];
        end
        if (q_reg == 4'd15) begin
          q_next = 4'd0;
          // A block accepted on the final quad overrides the shift and streams on.
          if (accept) begin
            for (int i = 0; i < BLOCKWORDS; i++)
              window_next[i] = bus.block_in[WORDBITS*i +: WORDBITS];
          end else begin
            state_next = IDLE;
          end
        end else begin
          q_next = q_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      q_reg        <= 4'd0;
      kw_valid_reg <= 1'b0;
      last_reg     <= 1'b0;
      quad_idx_reg <= 4'd0;
      for (int i = 0; i < BLOCKWORDS; i++) window_reg[i] <= '0;
      for (int i = 0; i < 4; i++) kw_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      q_reg        <= q_next;
      kw_valid_reg <= kw_valid_next;
      last_reg     <= last_next;
      quad_idx_reg <= quad_idx_next;
      window_reg   <= window_next;
      kw_reg       <= kw_next;
    end
  end

  assign bus.ready    = ready;
  assign bus.kw_valid = kw_valid_reg;
  assign bus.last     = last_reg;
  assign bus.quad_idx = quad_idx_reg;
  assign bus.KW0_out  = kw_reg[0];
  assign bus.KW1_out  = kw_reg[1];
  assign bus.KW2_out  = kw_reg[2];
  assign bus.KW3_out  = kw_reg[3];

endmodule
